icache_responder: RTL and testbench

//  Instruction-side memory responder: the target of fetch's i_mem_read / cache_pc / mem_resp handshake.

---
 rtl/icache_types.sv | 42 ++++
 rtl/icache_line_array.sv | 60 ++++++
 rtl/icache_responder.sv | 178 +++++++++++++++++
 tb/tb_icache_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_types.sv
// Shared I-cache types: line geometry, burst size, FSM state encoding and
// address field helpers used by icache_responder and icache_line_array.
package icache_types;

    localparam int LINE_BYTES = 32;
    localparam int LINE_BITS  = LINE_BYTES * 8;
    localparam int OFF_W      = 5;
    localparam int BEATS      = 4;
    localparam int BEAT_W     = 2;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        FILL,
        RESP
    } icache_state_t;

    function automatic logic [2:0] addr_word(input logic [31:0] a);
        return a[4:2];
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] a,
                                               input int unsigned idx_w);
        return (a >> OFF_W) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] a,
                                             input int unsigned idx_w);
        return a >> (OFF_W + idx_w);
    endfunction

    function automatic logic [31:0] line_addr(input logic [31:0] a);
        return {a[31:5], 5'b0};
    endfunction

    // Word w sits at bits [32*w +: 32]: beat w[2:1], half w[0], little-endian.
    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [2:0] w);
        return line[{w, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the direct-mapped I-cache.
// Ports: clk, rst (async active-low, clears valid bits only);
//   rd_idx -> rd_valid/rd_tag/rd_line (combinational read);
//   wr_en/wr_idx/wr_tag/wr_line (install a full line, sets valid);
//   inv_all (clear every valid bit at the next edge, wins over wr_en).
module icache_line_array
    import icache_types::*;
#(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IDX_W-1:0]     rd_idx,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_BITS-1:0] rd_line,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_idx,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_BITS-1:0] wr_line,
    input  logic                 inv_all
);

    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  valid_d;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[wr_idx] = 1'b1;
        end
        if (inv_all) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped read-only I-cache answering fetch requests, refilling lines
// from physical memory with a 4-beat 64-bit burst.
// Ports: clk, rst (async active-low);
//   fetch side : i_mem_read, i_mem_address -> i_mem_rdata, i_mem_resp; inv;
//   memory side: pmem_read, pmem_address <- pmem_rdata, pmem_resp;
//   hit_cnt/miss_cnt (saturating) only when ICACHE_PERF_CNT_EN is defined.
module icache_responder
    import icache_types::*;
#(
    parameter int NUM_SETS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_read,
    input  logic [31:0] i_mem_address,
    output logic [31:0] i_mem_rdata,
    output logic        i_mem_resp,
    input  logic        inv,
    output logic        pmem_read,
    output logic [31:0] pmem_address,
    input  logic [63:0] pmem_rdata,
    input  logic        pmem_resp
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = 32 - OFF_W - IDX_W;

    icache_state_t            state_q, state_d;
    logic [31:2]              req_addr_q, req_addr_d;
    logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                     pending_inv_q, pending_inv_d;
    logic [BEATS-1:0][63:0]   line_buf_q, line_buf_d;

    logic [31:0]              req_addr;
    logic [IDX_W-1:0]         req_idx;
    logic [TAG_W-1:0]         req_tag;
    logic                     rd_valid;
    logic [TAG_W-1:0]         rd_tag;
    logic [LINE_BITS-1:0]     rd_line;
    logic                     hit;
    logic                     wr_en;
    logic                     inv_all;

    assign req_addr = {req_addr_q, 2'b00};
    assign req_idx  = IDX_W'(addr_index(req_addr, IDX_W));
    assign req_tag  = TAG_W'(addr_tag(req_addr, IDX_W));
    assign hit      = rd_valid && (rd_tag == req_tag);

    icache_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (req_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_line  (rd_line),
        .wr_en    (wr_en),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_line  (line_buf_d),
        .inv_all  (inv_all)
    );

    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        beat_cnt_d    = beat_cnt_q;
        pending_inv_d = pending_inv_q;
        line_buf_d    = line_buf_q;
        inv_all       = 1'b0;
        wr_en         = 1'b0;
        i_mem_resp    = 1'b0;
        i_mem_rdata   = '0;
        unique case (state_q)
            IDLE: begin
                // A deferred invalidate left over from an abandoned fill
                // lands here as well.
                inv_all       = inv | pending_inv_q;
                pending_inv_d = 1'b0;
                if (i_mem_read) begin
                    req_addr_d = i_mem_address[31:2];
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    i_mem_resp    = 1'b1;
                    i_mem_rdata   = line_word(rd_line, addr_word(req_addr));
                    inv_all       = inv | pending_inv_q;
                    pending_inv_d = 1'b0;
                    state_d       = IDLE;
                end else begin
                    pending_inv_d = pending_inv_q | inv;
                    state_d       = FILL;
                end
            end
            FILL: begin
                pending_inv_d = pending_inv_q | inv;
                if (pmem_resp) begin
                    line_buf_d[beat_cnt_q] = pmem_rdata;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                        wr_en   = 1'b1;
                        // Fetch gave up: install the line but stay silent.
                        state_d = i_mem_read ? RESP : IDLE;
                    end
                end
            end
            RESP: begin
                i_mem_resp    = 1'b1;
                i_mem_rdata   = line_word(line_buf_q, addr_word(req_addr));
                inv_all       = inv | pending_inv_q;
                pending_inv_d = 1'b0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pmem_read    = (state_q == FILL);
    assign pmem_address = pmem_read ? line_addr(req_addr) : '0;

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == LOOKUP) begin
            if (hit && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_d = hit_cnt_q + 32'd1;
            end
            if (!hit && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            beat_cnt_q    <= '0;
            pending_inv_q <= 1'b0;
            line_buf_q    <= '0;
`ifdef ICACHE_PERF_CNT_EN
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            beat_cnt_q    <= beat_cnt_d;
            pending_inv_q <= pending_inv_d;
            line_buf_q    <= line_buf_d;
`ifdef ICACHE_PERF_CNT_EN
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// Self-checking bench for icache_responder: directed read table plus
// hand sequences for invalidate, dropped request and reset mid-refill.
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_read;
    logic [31:0] i_mem_address;
    logic [31:0] i_mem_rdata;
    logic        i_mem_resp;
    logic        inv;
    logic        pmem_read;
    logic [31:0] pmem_address;
    logic [63:0] pmem_rdata;
    logic        pmem_resp;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int mem_beat = 0;
    int mem_wait = 0;
    int mem_gap  = 0;
    int m_hit    = 0;
    int m_miss   = 0;

    typedef struct {
        logic [31:0] addr;
        bit          miss;
        int          gap;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    icache_responder #(.NUM_SETS(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_mem_read    (i_mem_read),
        .i_mem_address (i_mem_address),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_resp    (i_mem_resp),
        .inv           (inv),
        .pmem_read     (pmem_read),
        .pmem_address  (pmem_address),
        .pmem_rdata    (pmem_rdata),
        .pmem_resp     (pmem_resp)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt       (hit_cnt),
        .miss_cnt      (miss_cnt)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1111_2222;
    endfunction

    // Physical memory: beat k of a line = words 2k (low) and 2k+1 (high),
    // with mem_gap idle cycles before each beat.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(negedge clk);
            pmem_resp = 1'b0;
            if (!pmem_read) begin
                mem_beat = 0;
                mem_wait = mem_gap;
            end else if (mem_beat < 4) begin
                if (mem_wait > 0) begin
                    mem_wait--;
                end else begin
                    pmem_rdata = {mem_word(pmem_address + 32'(8 * mem_beat) + 32'd4),
                                  mem_word(pmem_address + 32'(8 * mem_beat))};
                    pmem_resp  = 1'b1;
                    mem_beat++;
                    mem_wait   = mem_gap;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_perf(input string nm);
`ifdef ICACHE_PERF_CNT_EN
        check({nm, " hit_cnt"}, hit_cnt, 32'(m_hit));
        check({nm, " miss_cnt"}, miss_cnt, 32'(m_miss));
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    task automatic start_read(input logic [31:0] a);
        @(posedge clk);
        #1;
        i_mem_address = a;
        i_mem_read    = 1'b1;
    endtask

    // exp_cyc = 0 skips the latency check (sequence already partly elapsed).
    task automatic wait_resp(input logic [31:0] a, input int exp_cyc,
                             input bit exp_miss, input string nm);
        int cyc = 0;
        bit got = 1'b0;
        bit saw = 1'b0;
        bit bad = 1'b0;
        while (!got && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (pmem_read) begin
                saw = 1'b1;
                if (pmem_address !== {a[31:5], 5'b0}) bad = 1'b1;
            end
            if (i_mem_resp) begin
                got = 1'b1;
                check({nm, " rdata"}, i_mem_rdata, mem_word({a[31:2], 2'b00}));
            end
        end
        #1;
        i_mem_read = 1'b0;
        check({nm, " resp"}, 32'(got), 32'd1);
        if (exp_cyc > 0) check({nm, " latency"}, 32'(cyc), 32'(exp_cyc));
        check({nm, " pmem_read"}, 32'(saw), 32'(exp_miss));
        check({nm, " pmem_address"}, 32'(bad), 32'd0);
        if (exp_miss) m_miss++;
        else m_hit++;
    endtask

    task automatic do_read(input logic [31:0] a, input bit miss, input int gap,
                           input string nm);
        mem_gap = gap;
        start_read(a);
        wait_resp(a, miss ? 7 + 4 * gap : 2, miss, nm);
    endtask

    task automatic wait_beats(input int n, input string nm);
        int k = 0;
        while (mem_beat < n && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        check({nm, " beats"}, 32'(mem_beat >= n), 32'd1);
    endtask

    initial begin
        int n_resp;
        vecs[0] = '{32'h0000_0060, 1'b1, 0};
        vecs[1] = '{32'h0000_0064, 1'b0, 0};
        vecs[2] = '{32'h0000_0260, 1'b1, 0};
        vecs[3] = '{32'h0000_0060, 1'b1, 0};
        vecs[4] = '{32'h0000_007C, 1'b0, 0};
        vecs[5] = '{32'h0000_0048, 1'b1, 3};
        vecs[6] = '{32'h0000_005C, 1'b0, 0};
        vecs[7] = '{32'hFFFF_FFE4, 1'b1, 1};
        vecs[8] = '{32'hFFFF_FFF8, 1'b0, 0};
        vecs[9] = '{32'h0000_0068, 1'b0, 0};

        rst           = 1'b1;
        i_mem_read    = 1'b0;
        i_mem_address = '0;
        inv           = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset i_mem_resp", 32'(i_mem_resp), 32'd0);
        check("reset i_mem_rdata", i_mem_rdata, 32'd0);
        check("reset pmem_read", 32'(pmem_read), 32'd0);
        check("reset pmem_address", pmem_address, 32'd0);
        check_perf("reset");
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            if (i == 4) check_perf("after cold/hit/conflict");
            do_read(vecs[i].addr, vecs[i].miss, vecs[i].gap, $sformatf("vec%0d", i));
        end
        check_perf("after table");

        // Invalidate mid-burst: response still delivered, line then gone.
        mem_gap = 1;
        start_read(32'h0000_0100);
        wait_beats(2, "inv_fill");
        inv = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
        wait_resp(32'h0000_0100, 0, 1'b1, "inv_fill");
        do_read(32'h0000_0100, 1'b1, 1, "inv_refetch");
        do_read(32'h0000_0060, 1'b1, 0, "inv_other_line");

        // Invalidate while idle.
        @(posedge clk);
        #1;
        inv = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
        do_read(32'h0000_0064, 1'b1, 0, "inv_idle");

        // Fetch drops its request mid-refill: no pulse, line installed.
        mem_gap = 0;
        start_read(32'h0000_0140);
        wait_beats(2, "drop");
        i_mem_read = 1'b0;
        m_miss++;
        n_resp = 0;
        repeat (20) begin
            @(negedge clk);
            if (i_mem_resp) n_resp++;
        end
        check("drop no resp", 32'(n_resp), 32'd0);
        check("drop pmem_read", 32'(pmem_read), 32'd0);
        do_read(32'h0000_0144, 1'b0, 0, "drop_hit");
        check_perf("before reset");

        // Reset after two beats of a refill.
        mem_gap = 0;
        start_read(32'h0000_0180);
        wait_beats(2, "rst_fill");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        i_mem_read = 1'b0;
        #1;
        check("rst_fill pmem_read", 32'(pmem_read), 32'd0);
        check("rst_fill i_mem_resp", 32'(i_mem_resp), 32'd0);
        m_hit  = 0;
        m_miss = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_perf("after reset");
        do_read(32'h0000_0180, 1'b1, 0, "rst_refill");
        do_read(32'h0000_0144, 1'b1, 0, "rst_valid_cleared");
        do_read(32'h0000_019C, 1'b0, 0, "rst_refill_hit");
        check_perf("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
